// File: rtl/rob_commit_pkg.sv
// Shared reorder-buffer entry layout, commit FSM states and sizing for the retirement stage.
// Imported by the commit stage and by the ROB owner upstream.
package rob_commit_pkg;

   localparam int ROB_ENTRIES  = 16;
   localparam int NUM_AREGS    = 32;
   localparam int NUM_PREGS    = 64;
   localparam int COMMIT_WIDTH = 2;

   localparam int ROB_IDX_W = $clog2(ROB_ENTRIES);
   localparam int AREG_W    = $clog2(NUM_AREGS);
   localparam int PREG_W    = $clog2(NUM_PREGS);

   typedef logic [ROB_IDX_W-1:0] rob_idx_t;
   typedef logic [ROB_IDX_W:0]   walk_cnt_t;
   typedef logic [AREG_W-1:0]    areg_t;
   typedef logic [PREG_W-1:0]    preg_t;

   typedef struct packed {
      logic  valid;
      logic  busy;
      preg_t preg;
      areg_t areg;
      logic  exception;
      logic  macroop_start;
      logic  macroop_end;
   } reorder_buffer;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      WALK  = 2'd1,
      FLUSH = 2'd2
   } commit_state_t;

   // Completed and clean: eligible to retire as far as this entry alone is concerned.
   function automatic logic entry_done(input logic valid, input logic busy, input logic exception);
      return valid && !busy && !exception;
   endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Head-window retire decision for the two oldest ROB entries; purely combinational.
// Holds back a macro-op whose second uop is not done by retiring neither uop.
module commit_select
   import rob_commit_pkg::*;
(
   input  reorder_buffer e0,
   input  reorder_buffer e1,
   output logic          retire0,
   output logic          retire1,
   output logic          exc_start
);

   logic e0_done;
   logic e1_done;
   logic e1_closes;
   logic unused_fields;

   assign e0_done = entry_done(e0.valid, e0.busy, e0.exception);
   assign e1_done = entry_done(e1.valid, e1.busy, e1.exception);

   // Nothing beyond E1 fits in this cycle, so E1 may only retire as the last uop of its macro-op.
   assign e1_closes = e1_done && e1.macroop_end;

   assign retire0   = e0_done && (e0.macroop_end || e1_closes);
   assign retire1   = retire0 && e1_closes;
   assign exc_start = e0.valid && !e0.busy && e0.exception;

   assign unused_fields = ^{e0.preg, e0.areg, e0.macroop_start,
                            e1.preg, e1.areg, e1.macroop_start};

endmodule

// File: rtl/rob_commit.sv
// In-order retirement: up to two uops per cycle from the ROB head, committed RAT, preg release, exception walk+flush.
// Decision is combinational on rob[]; head/crat/state update at the edge. commit_busy stalls upstream during WALK/FLUSH.
module rob_commit
   import rob_commit_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  reorder_buffer                 rob [ROB_ENTRIES],
   output logic [ROB_ENTRIES-1:0]        rob_retire,
   output logic                          rob_clear_all,
   output rob_idx_t                      rob_head,
   output logic [COMMIT_WIDTH-1:0]       free_valid,
   output logic [COMMIT_WIDTH-1:0][PREG_W-1:0] free_preg,
   output preg_t                         crat [NUM_AREGS],
   output logic                          flush,
   output logic                          exc_valid,
   output rob_idx_t                      exc_index,
   output logic                          commit_busy
);

   commit_state_t state, state_nxt;
   rob_idx_t      head, head_nxt;
   rob_idx_t      head_p1;
   rob_idx_t      walk_ptr, walk_ptr_nxt;
   rob_idx_t      walk_ptr_p1;
   walk_cnt_t     walk_cnt, walk_cnt_nxt;
   rob_idx_t      exc_idx, exc_idx_nxt;
   preg_t         crat_q [NUM_AREGS];

   logic retire0;
   logic retire1;
   logic exc_start;
   logic commit0;
   logic commit1;

   assign head_p1     = head + rob_idx_t'(1);
   assign walk_ptr_p1 = walk_ptr + rob_idx_t'(1);

   commit_select u_select (
      .e0        (rob[head]),
      .e1        (rob[head_p1]),
      .retire0   (retire0),
      .retire1   (retire1),
      .exc_start (exc_start)
   );

   assign commit0 = (state == RUN) && retire0;
   assign commit1 = (state == RUN) && retire1;

   always_comb begin
      state_nxt     = state;
      head_nxt      = head;
      walk_ptr_nxt  = walk_ptr;
      walk_cnt_nxt  = walk_cnt;
      exc_idx_nxt   = exc_idx;
      rob_retire    = '0;
      free_valid    = '0;
      free_preg     = '0;
      flush         = 1'b0;
      exc_valid     = 1'b0;
      rob_clear_all = 1'b0;
      commit_busy   = 1'b0;

      case (state)
         RUN: begin
            if (exc_start) begin
               state_nxt    = WALK;
               exc_idx_nxt  = head;
               walk_ptr_nxt = head;
               walk_cnt_nxt = '0;
            end else begin
               if (retire0) begin
                  rob_retire[head] = 1'b1;
                  free_valid[0]    = 1'b1;
                  free_preg[0]     = crat_q[rob[head].areg];
               end
               if (retire1) begin
                  rob_retire[head_p1] = 1'b1;
                  free_valid[1]       = 1'b1;
                  // Slot 1 overwriting slot 0's areg supersedes the mapping slot 0 just created.
                  free_preg[1] = (rob[head_p1].areg == rob[head].areg) ? rob[head].preg
                                                                       : crat_q[rob[head_p1].areg];
               end
               head_nxt = head + rob_idx_t'(retire0) + rob_idx_t'(retire1);
            end
         end

         WALK: begin
            commit_busy = 1'b1;
            if (rob[walk_ptr].valid) begin
               free_valid[0] = 1'b1;
               free_preg[0]  = rob[walk_ptr].preg;
               walk_ptr_nxt  = walk_ptr_p1;
               walk_cnt_nxt  = walk_cnt + walk_cnt_t'(1);
               // Look ahead so the flush follows the last free directly; the count covers a full ROB.
               if (!rob[walk_ptr_p1].valid || walk_cnt == walk_cnt_t'(ROB_ENTRIES - 1)) begin
                  state_nxt = FLUSH;
               end
            end else begin
               state_nxt = FLUSH;
            end
         end

         FLUSH: begin
            commit_busy   = 1'b1;
            flush         = 1'b1;
            exc_valid     = 1'b1;
            rob_clear_all = 1'b1;
            head_nxt      = '0;
            state_nxt     = RUN;
         end

         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         head     <= '0;
         walk_ptr <= '0;
         walk_cnt <= '0;
         exc_idx  <= '0;
      end else begin
         state    <= state_nxt;
         head     <= head_nxt;
         walk_ptr <= walk_ptr_nxt;
         walk_cnt <= walk_cnt_nxt;
         exc_idx  <= exc_idx_nxt;
      end
   end

   // Slot 1 is written last so a shared areg ends up mapped to the younger uop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_AREGS; i++) begin
            crat_q[i] <= preg_t'(i);
         end
      end else begin
         if (commit0) begin
            crat_q[rob[head].areg] <= rob[head].preg;
         end
         if (commit1) begin
            crat_q[rob[head_p1].areg] <= rob[head_p1].preg;
         end
      end
   end

   assign crat      = crat_q;
   assign rob_head  = head;
   assign exc_index = exc_idx;

endmodule

// File: tb/tb_rob_commit.sv
// Directed and random checks of rob_commit against a queue-style ROB model with macro-op grouping.
module tb_rob_commit;
   import rob_commit_pkg::*;

   logic                             clk;
   logic                             reset;
   reorder_buffer                    rob [ROB_ENTRIES];
   logic [ROB_ENTRIES-1:0]           rob_retire;
   logic                             rob_clear_all;
   rob_idx_t                         rob_head;
   logic [COMMIT_WIDTH-1:0]          free_valid;
   logic [COMMIT_WIDTH-1:0][PREG_W-1:0] free_preg;
   preg_t                            crat [NUM_AREGS];
   logic                             flush;
   logic                             exc_valid;
   rob_idx_t                         exc_index;
   logic                             commit_busy;

   int    total = 0;
   int    bad   = 0;
   int    m_head;
   int    occ;
   preg_t m_crat [NUM_AREGS];

   rob_commit dut (
      .clk           (clk),
      .reset         (reset),
      .rob           (rob),
      .rob_retire    (rob_retire),
      .rob_clear_all (rob_clear_all),
      .rob_head      (rob_head),
      .free_valid    (free_valid),
      .free_preg     (free_preg),
      .crat          (crat),
      .flush         (flush),
      .exc_valid     (exc_valid),
      .exc_index     (exc_index),
      .commit_busy   (commit_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish (bad=%0d)", bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_crat(input string tag);
      logic [191:0] o;
      logic [191:0] e;
      o = '0;
      e = '0;
      for (int i = 0; i < NUM_AREGS; i++) begin
         o[i*PREG_W +: PREG_W] = crat[i];
         e[i*PREG_W +: PREG_W] = m_crat[i];
      end
      chk(tag, o, e);
   endtask

   function automatic reorder_buffer mk(input logic v, input logic b, input logic x,
                                        input areg_t a, input preg_t p,
                                        input logic s, input logic e);
      reorder_buffer r;
      r.valid = v; r.busy = b; r.exception = x; r.areg = a; r.preg = p;
      r.macroop_start = s; r.macroop_end = e;
      return r;
   endfunction

   task automatic clear_rob();
      for (int i = 0; i < ROB_ENTRIES; i++) rob[i] = '0;
   endtask

   task automatic reset_model();
      m_head = 0;
      for (int i = 0; i < NUM_AREGS; i++) m_crat[i] = preg_t'(i);
   endtask

   // Whole macro-ops (ended by macroop_end) retire from the head while they are all done and fit in two slots.
   function automatic int model_count();
      int n;
      int g;
      bit ok;
      bit closed;
      reorder_buffer e;
      n = 0;
      while (n < COMMIT_WIDTH) begin
         g = 0; ok = 1; closed = 0;
         for (int j = n; j < COMMIT_WIDTH && !closed; j++) begin
            e = rob[(m_head + j) % ROB_ENTRIES];
            if (!(e.valid && !e.busy && !e.exception)) ok = 0;
            g++;
            if (e.macroop_end) closed = 1;
         end
         if (!ok || !closed) break;
         n += g;
      end
      return n;
   endfunction

   // Called at posedge+1; checks this cycle's retire outputs and the registered effect after the edge.
   task automatic run_cycle();
      int n;
      int idx;
      logic [ROB_ENTRIES-1:0]     exp_ret;
      logic [COMMIT_WIDTH-1:0]    exp_fv;
      logic [2*PREG_W-1:0]        exp_fp;
      n = model_count();
      exp_ret = '0; exp_fv = '0; exp_fp = '0;
      for (int k = 0; k < n; k++) begin
         idx = (m_head + k) % ROB_ENTRIES;
         exp_ret[idx] = 1'b1;
         exp_fv[k]    = 1'b1;
         exp_fp[k*PREG_W +: PREG_W] = m_crat[rob[idx].areg];
         m_crat[rob[idx].areg] = rob[idx].preg;
      end
      #1;
      chk("retire_mask", rob_retire, exp_ret);
      chk("free_valid", free_valid, exp_fv);
      chk("free_preg", free_preg, exp_fp);
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) rob[(m_head + k) % ROB_ENTRIES].valid = 1'b0;
      m_head = (m_head + n) % ROB_ENTRIES;
      occ -= n;
      chk("rob_head", rob_head, m_head);
      chk_crat("crat");
   endtask

   initial begin
      int  frees;
      bit  seen;
      int  tail;
      occ = 0;
      reset = 1'b1;
      clear_rob();
      reset_model();
      #3;
      chk("rst_crat5", crat[5], 5);
      chk("rst_head", rob_head, 0);
      chk("rst_flush", flush, 0);
      chk("rst_free_valid", free_valid, 0);
      chk("rst_retire", rob_retire, 0);
      chk("rst_busy", commit_busy, 0);
      #5 reset = 1'b0;
      @(posedge clk); #1;

      // Two retirements to the same areg.
      rob[0] = mk(1, 0, 0, 3, 40, 1, 1);
      rob[1] = mk(1, 0, 0, 3, 41, 1, 1);
      #1;
      chk("t2_retire", rob_retire, 16'h0003);
      chk("t2_free_preg", free_preg, {6'd40, 6'd3});
      run_cycle();
      chk("t2_crat3", crat[3], 41);
      chk("t2_head", rob_head, 2);

      // Busy second entry, then a macro-op held until its tail completes.
      rob[2] = mk(1, 0, 0, 4, 42, 1, 1);
      rob[3] = mk(1, 1, 0, 5, 43, 1, 1);
      run_cycle();
      chk("t3_head_one", rob_head, 3);
      rob[3] = mk(1, 0, 0, 5, 43, 1, 0);
      rob[4] = mk(1, 1, 0, 6, 44, 0, 1);
      #1;
      chk("t3_macro_hold", rob_retire, 0);
      run_cycle();
      chk("t3_head_held", rob_head, 3);
      rob[4].busy = 1'b0;
      run_cycle();
      chk("t3_macro_pair", rob_head, 5);

      // Advance to head 15 and retire across the wrap.
      for (int i = 5; i < 15; i++) rob[i] = mk(1, 0, 0, areg_t'(i), preg_t'(i + 20), 1, 1);
      repeat (5) run_cycle();
      chk("t4_head15", rob_head, 15);
      rob[15] = mk(1, 0, 0, 9, 60, 1, 1);
      rob[0]  = mk(1, 0, 0, 10, 61, 1, 1);
      #1;
      chk("t4_wrap_retire", rob_retire, 16'h8001);
      run_cycle();
      chk("t4_head_wrap", rob_head, 1);
      rob[1] = mk(1, 0, 0, 11, 62, 1, 1);
      run_cycle();

      // Exception at head 2 with two younger entries.
      rob[2] = mk(1, 0, 1, 12, 50, 1, 1);
      rob[3] = mk(1, 1, 0, 13, 51, 1, 1);
      rob[4] = mk(1, 0, 0, 14, 52, 1, 1);
      #1;
      chk("t5_no_retire", rob_retire, 0);
      chk("t5_no_free", free_valid, 0);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         chk("t5_walk_valid", free_valid, 2'b01);
         chk("t5_walk_preg", free_preg[0], 50 + k);
         chk("t5_walk_noflush", flush, 0);
         chk("t5_walk_busy", commit_busy, 1);
         @(posedge clk); #1;
      end
      chk("t5_flush", flush, 1);
      chk("t5_exc_valid", exc_valid, 1);
      chk("t5_clear_all", rob_clear_all, 1);
      chk("t5_exc_index", exc_index, 2);
      chk("t5_flush_free", free_valid, 0);
      @(posedge clk); #1;
      clear_rob();
      m_head = 0;
      chk("t5_head0", rob_head, 0);
      chk("t5_flush_done", flush, 0);
      chk("t5_busy_done", commit_busy, 0);
      chk_crat("t5_crat_kept");

      // Reset in the middle of a walk.
      rob[0] = mk(1, 0, 1, 1, 20, 1, 1);
      for (int i = 1; i < 6; i++) rob[i] = mk(1, 1, 0, areg_t'(i), preg_t'(20 + i), 1, 1);
      @(posedge clk); #1;
      chk("t6_walk_started", commit_busy, 1);
      reset = 1'b1;
      #1;
      chk("t6_rst_busy", commit_busy, 0);
      chk("t6_rst_free", free_valid, 0);
      chk("t6_rst_flush", flush, 0);
      chk("t6_rst_crat3", crat[3], 3);
      clear_rob();
      reset_model();
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("t6_no_flush", flush, 0);
      end
      chk_crat("t6_crat_reset");

      // Full ROB with the head excepting: all sixteen entries are released.
      for (int i = 0; i < ROB_ENTRIES; i++) rob[i] = mk(1, 0, i == 0, areg_t'(i), preg_t'(30 + i), 1, 1);
      @(posedge clk); #1;
      frees = 0;
      seen  = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (flush) seen = 1;
         else if (free_valid[0]) begin
            chk("t6_full_preg", free_preg[0], 30 + frees);
            frees++;
         end
         if (!seen) begin
            @(posedge clk); #1;
         end
      end
      chk("t6_full_frees", frees, 16);
      chk("t6_full_flush_seen", seen, 1);
      chk("t6_full_exc_index", exc_index, 0);
      @(posedge clk); #1;
      clear_rob();
      m_head = 0;
      chk("t6_full_head0", rob_head, 0);

      // Random traffic: single uops and two-uop macro-ops, random completion order.
      occ = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < ROB_ENTRIES; i++) begin
            if (rob[i].valid && rob[i].busy && $urandom_range(0, 2) == 0) rob[i].busy = 1'b0;
         end
         if ($urandom_range(0, 3) != 0) begin
            tail = (m_head + occ) % ROB_ENTRIES;
            if (occ <= ROB_ENTRIES - 2 && $urandom_range(0, 3) == 0) begin
               rob[tail] = mk(1, 1'($urandom_range(0, 1)), 0, areg_t'($urandom_range(0, 7)),
                              preg_t'($urandom_range(0, 63)), 1, 0);
               rob[(tail + 1) % ROB_ENTRIES] = mk(1, 1'($urandom_range(0, 1)), 0,
                              areg_t'($urandom_range(0, 7)), preg_t'($urandom_range(0, 63)), 0, 1);
               occ += 2;
            end else if (occ <= ROB_ENTRIES - 1) begin
               rob[tail] = mk(1, 1'($urandom_range(0, 1)), 0, areg_t'($urandom_range(0, 7)),
                              preg_t'($urandom_range(0, 63)), 1, 1);
               occ += 1;
            end
         end
         run_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
